// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Holds the instruction/address bus widths, the canonical NOP and the storage entry layout.
package if_id_queue_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

endpackage

// File: rtl/if_id_queue.sv
// First-word-fall-through queue between fetch and decode.
// Flush empties it in one edge; when empty it presents a NOP to decode.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_flush,
  input  logic              I_if_valid,
  input  logic [INST_W-1:0] I_if_inst,
  input  logic [ADDR_W-1:0] I_if_addr,
  output logic              O_if_ready,
  output logic              O_stallreq,
  output logic              O_id_valid,
  output logic [INST_W-1:0] O_id_inst,
  output logic [ADDR_W-1:0] O_id_addr,
  input  logic              I_id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Ready and valid come only from registered count, so fetch and decode never see a loop.
  assign O_if_ready = (count != FULL_COUNT);
  assign O_stallreq = ~O_if_ready;
  assign O_id_valid = (count != '0);
  assign O_id_inst  = O_id_valid ? mem[rd_ptr].inst : INST_NOP;
  assign O_id_addr  = O_id_valid ? mem[rd_ptr].addr : ZERO_WORD;

  assign push = I_if_valid & O_if_ready & ~I_flush;
  assign pop  = O_id_valid & I_id_ready & ~I_flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{inst: I_if_inst, addr: I_if_addr};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (I_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_flush;
  logic        I_if_valid;
  logic [31:0] I_if_inst;
  logic [31:0] I_if_addr;
  logic        O_if_ready;
  logic        O_stallreq;
  logic        O_id_valid;
  logic [31:0] O_id_inst;
  logic [31:0] O_id_addr;
  logic        I_id_ready;

  int checks = 0;
  int failures = 0;
  logic [63:0] model_q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .I_flush(I_flush),
    .I_if_valid(I_if_valid), .I_if_inst(I_if_inst), .I_if_addr(I_if_addr),
    .O_if_ready(O_if_ready), .O_stallreq(O_stallreq),
    .O_id_valid(O_id_valid), .O_id_inst(O_id_inst), .O_id_addr(O_id_addr),
    .I_id_ready(I_id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit v;
    v = (model_q.size() != 0);
    chk({tag, "_valid"}, 64'(O_id_valid), 64'(v));
    chk({tag, "_inst"},  64'(O_id_inst),  v ? 64'(model_q[0][63:32]) : 64'(NOP));
    chk({tag, "_addr"},  64'(O_id_addr),  v ? 64'(model_q[0][31:0])  : 64'd0);
    chk({tag, "_ready"}, 64'(O_if_ready), 64'(model_q.size() < DEPTH));
    chk({tag, "_stall"}, 64'(O_stallreq), 64'(model_q.size() >= DEPTH));
  endtask

  // One clock edge with the currently driven inputs; returns whether fetch's pair was taken.
  task automatic step(output bit accepted);
    bit push, pop;
    push = I_if_valid && (model_q.size() < DEPTH) && !I_flush;
    pop  = (model_q.size() != 0) && I_id_ready && !I_flush;
    @(posedge clk);
    if (I_flush) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({I_if_inst, I_if_addr});
    end
    accepted = push;
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    logic [31:0] pc;
    rst = 1'b1; I_flush = 0; I_if_valid = 0; I_if_inst = 0; I_if_addr = 0; I_id_ready = 0;
    #12 rst = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    step(acc);
    check_outputs("idle");

    // Single push, decode stalled; appears one cycle later.
    I_if_valid = 1; I_if_inst = 32'h0010_0093; I_if_addr = 32'h8000_0000;
    check_outputs("pre_push");
    step(acc);
    I_if_valid = 0;
    chk("single_inst", 64'(O_id_inst), 64'h0010_0093);
    chk("single_addr", 64'(O_id_addr), 64'h8000_0000);
    check_outputs("single");
    I_flush = 1; step(acc); I_flush = 0;
    check_outputs("clear");

    // Fill to full, third refused, then drain with fetch holding its PC.
    pc = 32'h8000_0000;
    I_if_valid = 1; I_id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      I_if_addr = pc; I_if_inst = pc ^ 32'h0000_0013;
      step(acc);
      if (acc) pc += 4;
      check_outputs("fill");
    end
    chk("full_stall", 64'(O_stallreq), 64'd1);
    chk("full_head", 64'(O_id_addr), 64'h8000_0000);
    I_id_ready = 1;
    for (int i = 0; i < 4; i++) begin
      I_if_addr = pc; I_if_inst = pc ^ 32'h0000_0013;
      I_if_valid = (pc <= 32'h8000_0008);
      step(acc);
      if (acc) pc += 4;
      check_outputs("drain");
    end
    chk("third_taken", 64'(pc), 64'h8000_000c);

    // Streaming push+pop with the queue holding one entry.
    I_flush = 1; step(acc); I_flush = 0;
    I_if_valid = 1; I_id_ready = 1; pc = 32'h8000_1000;
    for (int i = 0; i < 10; i++) begin
      I_if_addr = pc; I_if_inst = 32'h0000_0013 + pc;
      step(acc);
      if (acc) pc += 4;
      check_outputs("stream");
    end

    // Flush with count=2 and a simultaneous push.
    I_id_ready = 0;
    for (int i = 0; i < 2; i++) begin
      I_if_addr = pc; step(acc); if (acc) pc += 4;
    end
    chk("pre_flush_stall", 64'(O_stallreq), 64'd1);
    I_flush = 1; I_if_valid = 1; step(acc); I_flush = 0; I_if_valid = 0;
    check_outputs("flush");
    chk("flush_nop", 64'(O_id_inst), 64'(NOP));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      I_if_valid = ($urandom_range(0, 3) != 0);
      I_id_ready = ($urandom_range(0, 2) != 0);
      I_flush    = ($urandom_range(0, 29) == 0);
      I_if_inst  = $urandom();
      I_if_addr  = $urandom();
      step(acc);
      check_outputs("rand");
    end

    // Asynchronous reset with one entry held.
    I_flush = 1; step(acc); I_flush = 0;
    I_if_valid = 1; I_id_ready = 0; I_if_inst = 32'hdead_beef; I_if_addr = 32'h8000_2000;
    step(acc); I_if_valid = 0;
    check_outputs("pre_rst");
    #2 rst = 1'b1;
    #1 model_q.delete();
    check_outputs("async_rst");
    #1 rst = 1'b0;
    step(acc);
    check_outputs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
